// File: rtl/mailbox_pkg.sv
// Shared constants for the mailbox register file: register byte offsets,
// handshake FSM state encodings and CTRL register bit positions.
package mailbox_pkg;

    localparam logic [3:0] MB_DATA   = 4'h0;
    localparam logic [3:0] MB_STATUS = 4'h4;
    localparam logic [3:0] MB_CTRL   = 4'h8;
    localparam logic [3:0] MB_LEVEL  = 4'hC;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] W_ACK = 2'd1;
    localparam logic [1:0] R_ACK = 2'd2;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_FLUSH  = 1;

endpackage

// File: rtl/mailbox_fifo.sv
// Circular message buffer for the mailbox. Pointers wrap on their own because
// DEPTH is a power of two; count carries the extra bit to tell full from empty.
module mailbox_fifo #(
    parameter int W_WIDTH_SYS = 32,
    parameter int DEPTH       = 8,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                   pclk_i,
    input  logic                   preset_i,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W_WIDTH_SYS-1:0] wdata,
    output logic [W_WIDTH_SYS-1:0] rdata,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty
);
    import mailbox_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [W_WIDTH_SYS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Storage needs no reset; only pointers and count define what is valid.
    always_ff @(posedge pclk_i) begin
        if (push && !full) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (push && !full) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            count  <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mailbox_regfile.sv
// Responder for the internal req/ack register bus: 4-phase handshake FSM,
// address decode, CTRL/LEVEL registers and the registered FIFO-level interrupt.
module mailbox_regfile #(
    parameter int W_WIDTH_SYS = 32,
    parameter int WIDTH_ADDR  = 32,
    parameter int DEPTH       = 8,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                   pclk_i,
    input  logic                   preset_i,
    input  logic                   req_w_i,
    input  logic                   req_r_i,
    input  logic [WIDTH_ADDR-1:0]  addr_i,
    input  logic [W_WIDTH_SYS-1:0] data_i,
    output logic                   ack_w_o,
    output logic                   err_w_o,
    output logic                   ack_r_o,
    output logic                   err_r_o,
    output logic [W_WIDTH_SYS-1:0] rdata_o,
    output logic                   irq_o
);
    import mailbox_pkg::*;

    logic [1:0]             state;
    logic                   irq_en;
    logic [CNT_W-1:0]       level;

    logic                   wr_go, rd_go;
    logic                   addr_bad;
    logic                   sel_data, sel_status, sel_ctrl, sel_level;
    logic                   lvl_bad;
    logic                   wr_err, rd_err;
    logic [W_WIDTH_SYS-1:0] rd_val;

    logic                   fifo_push, fifo_pop, fifo_flush;
    logic [W_WIDTH_SYS-1:0] fifo_rdata;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full, fifo_empty;

    // Only IDLE starts a transaction, so every side effect fires once per handshake.
    assign wr_go = (state == IDLE) && req_w_i;
    assign rd_go = (state == IDLE) && !req_w_i && req_r_i;

    assign addr_bad   = (|addr_i[WIDTH_ADDR-1:4]) || (|addr_i[1:0]);
    assign sel_data   = !addr_bad && (addr_i[3:0] == MB_DATA);
    assign sel_status = !addr_bad && (addr_i[3:0] == MB_STATUS);
    assign sel_ctrl   = !addr_bad && (addr_i[3:0] == MB_CTRL);
    assign sel_level  = !addr_bad && (addr_i[3:0] == MB_LEVEL);

    assign lvl_bad = (data_i == '0) || (data_i > W_WIDTH_SYS'(DEPTH));
    assign wr_err  = addr_bad || sel_status || (sel_data && fifo_full) || (sel_level && lvl_bad);
    assign rd_err  = addr_bad || (sel_data && fifo_empty);

    assign fifo_push  = wr_go && sel_data && !fifo_full;
    assign fifo_pop   = rd_go && sel_data && !fifo_empty;
    assign fifo_flush = wr_go && sel_ctrl && data_i[CTRL_FLUSH];

    always_comb begin
        rd_val = '0;
        if (sel_data && !fifo_empty) begin
            rd_val = fifo_rdata;
        end else if (sel_status) begin
            rd_val[CNT_W+1:0] = {fifo_count, fifo_full, fifo_empty};
        end else if (sel_ctrl) begin
            rd_val[CTRL_IRQ_EN] = irq_en;
        end else if (sel_level) begin
            rd_val[CNT_W-1:0] = level;
        end
    end

    mailbox_fifo #(
        .W_WIDTH_SYS(W_WIDTH_SYS),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .pclk_i  (pclk_i),
        .preset_i(preset_i),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .wdata   (data_i),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state   <= IDLE;
            ack_w_o <= 1'b0;
            err_w_o <= 1'b0;
            ack_r_o <= 1'b0;
            err_r_o <= 1'b0;
            rdata_o <= '0;
            irq_en  <= 1'b0;
            level   <= CNT_W'(DEPTH);
            irq_o   <= 1'b0;
        end else begin
            irq_o <= irq_en && (fifo_count >= level);
            case (state)
                IDLE: begin
                    if (wr_go) begin
                        ack_w_o <= 1'b1;
                        err_w_o <= wr_err;
                        state   <= W_ACK;
                        if (sel_ctrl) begin
                            irq_en <= data_i[CTRL_IRQ_EN];
                        end
                        if (sel_level && !lvl_bad) begin
                            level <= data_i[CNT_W-1:0];
                        end
                    end else if (rd_go) begin
                        ack_r_o <= 1'b1;
                        err_r_o <= rd_err;
                        rdata_o <= rd_val;
                        state   <= R_ACK;
                    end
                end
                W_ACK: begin
                    if (!req_w_i) begin
                        ack_w_o <= 1'b0;
                        err_w_o <= 1'b0;
                        state   <= IDLE;
                    end
                end
                R_ACK: begin
                    if (!req_r_i) begin
                        ack_r_o <= 1'b0;
                        err_r_o <= 1'b0;
                        rdata_o <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mailbox_regfile.sv
// Directed bench for mailbox_regfile (DEPTH=8): a table of single handshakes
// plus hand-written sequences for irq timing, full/wrap, held requests and reset.
module tb_mailbox_regfile;

    logic        pclk_i = 1'b0;
    logic        preset_i;
    logic        req_w_i, req_r_i;
    logic [31:0] addr_i, data_i;
    logic        ack_w_o, err_w_o, ack_r_o, err_r_o, irq_o;
    logic [31:0] rdata_o;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    mailbox_regfile #(
        .W_WIDTH_SYS(32),
        .WIDTH_ADDR (32),
        .DEPTH      (8)
    ) dut (
        .pclk_i  (pclk_i),
        .preset_i(preset_i),
        .req_w_i (req_w_i),
        .req_r_i (req_r_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .ack_w_o (ack_w_o),
        .err_w_o (err_w_o),
        .ack_r_o (ack_r_o),
        .err_r_o (err_r_o),
        .rdata_o (rdata_o),
        .irq_o   (irq_o)
    );

    always #5 pclk_i = ~pclk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One full 4-phase handshake, called at a falling edge; returns err/rdata seen while ack was high.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic err, output logic [31:0] rdata);
        int n;
        addr_i = addr;
        data_i = wdata;
        if (wr) req_w_i = 1'b1;
        else    req_r_i = 1'b1;
        n = 0;
        do begin
            @(negedge pclk_i);
            n++;
        end while (((wr ? ack_w_o : ack_r_o) !== 1'b1) && n < 20);
        checkOutput("ack_rise_latency", 32'(n), 32'd1);
        err   = wr ? err_w_o : err_r_o;
        rdata = rdata_o;
        req_w_i = 1'b0;
        req_r_i = 1'b0;
        n = 0;
        do begin
            @(negedge pclk_i);
            n++;
        end while (((wr ? ack_w_o : ack_r_o) !== 1'b0) && n < 20);
        checkOutput("ack_fall_latency", 32'(n), 32'd1);
    endtask

    task automatic runVector(input string name, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata);
        logic        err;
        logic [31:0] rdata;
        applyStimulus(wr, addr, wdata, err, rdata);
        checkOutput({name, "_err"}, 32'(err), 32'(exp_err));
        if (!wr) checkOutput({name, "_rdata"}, rdata, exp_rdata);
    endtask

    task automatic addVec(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata);
        vec_t v;
        v.wr        = wr;
        v.addr      = addr;
        v.wdata     = wdata;
        v.exp_err   = exp_err;
        v.exp_rdata = exp_rdata;
        vecs.push_back(v);
    endtask

    initial begin
        // STATUS encoding for DEPTH=8: {count[3:0], full, empty} in bits [5:0].
        addVec(1, 32'h0,  32'h11, 0, 32'h0);
        addVec(1, 32'h0,  32'h22, 0, 32'h0);
        addVec(1, 32'h0,  32'h33, 0, 32'h0);
        addVec(0, 32'h4,  32'h0,  0, 32'h0C);
        addVec(0, 32'h0,  32'h0,  0, 32'h11);
        addVec(0, 32'h0,  32'h0,  0, 32'h22);
        addVec(0, 32'h0,  32'h0,  0, 32'h33);
        addVec(0, 32'h4,  32'h0,  0, 32'h01);
        addVec(0, 32'h0,  32'h0,  1, 32'h0);
        addVec(0, 32'h4,  32'h0,  0, 32'h01);
        addVec(1, 32'h4,  32'h5,  1, 32'h0);
        addVec(1, 32'h10, 32'h7,  1, 32'h0);
        addVec(0, 32'h10, 32'h0,  1, 32'h0);
        addVec(0, 32'h4,  32'h0,  0, 32'h01);
        addVec(0, 32'hC,  32'h0,  0, 32'h08);
        addVec(0, 32'h8,  32'h0,  0, 32'h00);
        addVec(1, 32'hC,  32'h0,  1, 32'h0);
        addVec(1, 32'hC,  32'h9,  1, 32'h0);
        addVec(0, 32'hC,  32'h0,  0, 32'h08);
        addVec(1, 32'hC,  32'h3,  0, 32'h0);
        addVec(0, 32'hC,  32'h0,  0, 32'h03);
        addVec(1, 32'h8,  32'h1,  0, 32'h0);
        addVec(0, 32'h8,  32'h0,  0, 32'h01);

        preset_i = 1'b1;
        req_w_i  = 1'b0;
        req_r_i  = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        repeat (2) @(negedge pclk_i);
        checkOutput("reset_flags", {27'd0, ack_w_o, err_w_o, ack_r_o, err_r_o, irq_o}, 32'h0);
        checkOutput("reset_rdata", rdata_o, 32'h0);
        preset_i = 1'b0;
        @(negedge pclk_i);

        for (int i = 0; i < vecs.size(); i++) begin
            runVector($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // irq: irq_en=1, LEVEL=3 from the table; rises the cycle after the 3rd push lands.
        runVector("irq_w1", 1, 32'h0, 32'hA1, 0, 32'h0);
        runVector("irq_w2", 1, 32'h0, 32'hA2, 0, 32'h0);
        checkOutput("irq_below_level", 32'(irq_o), 32'd0);
        addr_i  = 32'h0;
        data_i  = 32'hA3;
        req_w_i = 1'b1;
        @(negedge pclk_i);
        checkOutput("irq_w3_ack", 32'(ack_w_o), 32'd1);
        checkOutput("irq_same_cycle", 32'(irq_o), 32'd0);
        req_w_i = 1'b0;
        @(negedge pclk_i);
        checkOutput("irq_next_cycle", 32'(irq_o), 32'd1);
        checkOutput("irq_w3_ack_drop", 32'(ack_w_o), 32'd0);
        runVector("irq_pop", 0, 32'h0, 32'h0, 0, 32'hA1);
        checkOutput("irq_after_pop", 32'(irq_o), 32'd0);
        runVector("level_zero", 1, 32'hC, 32'h0, 1, 32'h0);
        runVector("level_kept", 0, 32'hC, 32'h0, 0, 32'h3);
        runVector("flush", 1, 32'h8, 32'h3, 0, 32'h0);
        runVector("flush_status", 0, 32'h4, 32'h0, 0, 32'h1);
        runVector("flush_ctrl", 0, 32'h8, 32'h0, 0, 32'h1);
        runVector("irq_off", 1, 32'h8, 32'h0, 0, 32'h0);

        // Offset pointers by 3 so the fill below wraps mid-sequence.
        for (int i = 0; i < 3; i++) runVector("pre_w", 1, 32'h0, 32'h300 + i, 0, 32'h0);
        for (int i = 0; i < 3; i++) runVector("pre_r", 0, 32'h0, 32'h0, 0, 32'h300 + i);
        for (int i = 0; i < 9; i++) runVector($sformatf("fill_w%0d", i), 1, 32'h0, 32'h100 + i, (i == 8), 32'h0);
        runVector("full_status", 0, 32'h4, 32'h0, 0, 32'h22);
        for (int i = 0; i < 8; i++) runVector($sformatf("drain_r%0d", i), 0, 32'h0, 32'h0, 0, 32'h100 + i);
        runVector("drained_status", 0, 32'h4, 32'h0, 0, 32'h1);
        runVector("empty_read", 0, 32'h0, 32'h0, 1, 32'h0);

        // Request held for 5 cycles: ack stays up, exactly one push.
        addr_i  = 32'h0;
        data_i  = 32'h55;
        req_w_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge pclk_i);
            checkOutput($sformatf("hold_ack%0d", k), {30'd0, ack_w_o, err_w_o}, 32'h2);
        end
        req_w_i = 1'b0;
        @(negedge pclk_i);
        checkOutput("hold_ack_drop", 32'(ack_w_o), 32'd0);
        runVector("hold_status", 0, 32'h4, 32'h0, 0, 32'h4);
        runVector("bad_w_status", 1, 32'h4, 32'hFF, 1, 32'h0);
        runVector("bad_w_addr", 1, 32'h10, 32'hFF, 1, 32'h0);
        runVector("no_side_effect", 0, 32'h4, 32'h0, 0, 32'h4);
        runVector("ctrl_on", 1, 32'h8, 32'h1, 0, 32'h0);

        // Reset while a read ack is being held.
        addr_i  = 32'h4;
        req_r_i = 1'b1;
        @(negedge pclk_i);
        checkOutput("rst_pre_ack", 32'(ack_r_o), 32'd1);
        checkOutput("rst_pre_rdata", rdata_o, 32'h4);
        #2 preset_i = 1'b1;
        #1;
        checkOutput("rst_mid_flags", {27'd0, ack_w_o, err_w_o, ack_r_o, err_r_o, irq_o}, 32'h0);
        checkOutput("rst_mid_rdata", rdata_o, 32'h0);
        req_r_i = 1'b0;
        @(negedge pclk_i);
        preset_i = 1'b0;
        @(negedge pclk_i);
        runVector("post_rst_status", 0, 32'h4, 32'h0, 0, 32'h1);
        runVector("post_rst_level", 0, 32'hC, 32'h0, 0, 32'h8);
        runVector("post_rst_ctrl", 0, 32'h8, 32'h0, 0, 32'h0);
        runVector("post_rst_w", 1, 32'h0, 32'h77, 0, 32'h0);
        runVector("post_rst_r", 0, 32'h0, 32'h0, 0, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
